// File: rtl/mem_responder.sv
// mem_responder: word-organised synchronous RAM behind the core's memory port.
// One request per cycle (no valid/ready): byte-lane writes, 1-cycle registered
// read data, and illegal-access flagging with a saturating debug counter.
// Optional build macro MEM_CLEAR_ON_RESET_EN adds a reset-triggered clear sweep
// that fills every word with INIT_WORD before requests are accepted.
module mem_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter string       INIT_FILE  = "",
  parameter logic [31:0] INIT_WORD  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        write_en,
  input  logic [3:0]  data_en,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        init_busy,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [7:0]  fault_count
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  logic [31:0]           mem_q [WORDS];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  out_of_range;
  logic                  misaligned;
  logic                  illegal;
  logic                  busy;
  logic                  accept;
  logic                  sweep_we;
  logic [DEPTH_LOG2-1:0] sweep_idx;
  logic [31:0]           lane_mask;

  logic [31:0] data_q;
  logic        fault_q;
  logic [31:0] fault_addr_q;
  logic [7:0]  fault_count_q;

  assign idx          = addr[DEPTH_LOG2+1:2];
  // Any set bit above the word index puts the byte address past the end.
  assign out_of_range = |addr[31:DEPTH_LOG2+2];
  // A request with no lanes enabled is a no-op, so alignment only matters with lanes on.
  assign misaligned   = (addr[1:0] != 2'b00) && (data_en != 4'b0000);
  assign illegal      = out_of_range || misaligned;
  assign accept       = !busy && !illegal;

  // Expand byte-lane enables into a 32-bit mask.
  always_comb begin
    lane_mask = '0;
    for (int k = 0; k < 4; k++) begin
      lane_mask[8*k +: 8] = {8{data_en[k]}};
    end
  end

`ifdef MEM_CLEAR_ON_RESET_EN
  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t                state_q;
  logic [DEPTH_LOG2-1:0] ptr_q;
  logic                  busy_q;

  // Clear-sweep FSM: walk the pointer over every word, then open for requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        S_CLEAR: begin
          ptr_q <= ptr_q + DEPTH_LOG2'(1);
          if (ptr_q == '1) begin
            state_q <= S_READY;
            busy_q  <= 1'b0;
          end
        end
        S_READY: begin
          state_q <= S_READY;
        end
        default: begin
          state_q <= S_CLEAR;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign sweep_we  = (state_q == S_CLEAR);
  assign sweep_idx = ptr_q;
`else
  assign busy      = 1'b0;
  assign sweep_we  = 1'b0;
  assign sweep_idx = '0;
`endif

  // Memory write port: the clear sweep owns the array while it runs.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem_q[sweep_idx] <= INIT_WORD;
    end else if (accept && write_en) begin
      for (int k = 0; k < 4; k++) begin
        if (data_en[k]) mem_q[idx][8*k +: 8] <= data_i[8*k +: 8];
      end
    end
  end

  // Registered response: read data sampled before the write lands (old data),
  // plus fault pulse, last faulting address and saturating fault counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q        <= '0;
      fault_q       <= 1'b0;
      fault_addr_q  <= '0;
      fault_count_q <= '0;
    end else begin
      fault_q <= 1'b0;
      if (busy) begin
        data_q <= '0;
      end else if (illegal) begin
        data_q       <= '0;
        fault_q      <= 1'b1;
        fault_addr_q <= addr;
        if (fault_count_q != 8'hFF) fault_count_q <= fault_count_q + 8'd1;
      end else begin
        data_q <= mem_q[idx] & lane_mask;
      end
    end
  end

  assign data_o      = data_q;
  assign init_busy   = busy;
  assign fault       = fault_q;
  assign fault_addr  = fault_addr_q;
  assign fault_count = fault_count_q;

endmodule
